// File: rtl/biriscv_issue_sched.sv
// Dual-issue scheduler: hazard checks, long-latency register scoreboard,
// divider/LSU structural limits and CSR/fence serialisation.
module biriscv_issue_sched #(
  parameter int unsigned SUPPORT_DUAL_ISSUE = 1,
  parameter int unsigned MUL_LATENCY        = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       slot0_valid_i,
  input  logic       slot0_exec_i,
  input  logic       slot0_lsu_i,
  input  logic       slot0_branch_i,
  input  logic       slot0_mul_i,
  input  logic       slot0_div_i,
  input  logic       slot0_csr_i,
  input  logic       slot0_load_i,
  input  logic       slot0_rd_valid_i,
  input  logic [4:0] slot0_rd_i,
  input  logic [4:0] slot0_ra_i,
  input  logic [4:0] slot0_rb_i,
  input  logic       slot1_valid_i,
  input  logic       slot1_exec_i,
  input  logic       slot1_lsu_i,
  input  logic       slot1_branch_i,
  input  logic       slot1_mul_i,
  input  logic       slot1_div_i,
  input  logic       slot1_csr_i,
  input  logic       slot1_load_i,
  input  logic       slot1_rd_valid_i,
  input  logic [4:0] slot1_rd_i,
  input  logic [4:0] slot1_ra_i,
  input  logic [4:0] slot1_rb_i,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic       wb_load_valid_i,
  input  logic [4:0] wb_load_rd_i,
  input  logic       wb_div_valid_i,
  input  logic       csr_complete_i,
  output logic       issue0_o,
  output logic       issue1_o,
  output logic       div_busy_o,
  output logic       serial_o,
  output logic [31:0] scoreboard_o
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned NREG  = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic              div_busy_q;
  logic [REG_W-1:0]  div_rd_q;
  logic              mul_v_q  [MUL_LATENCY];
  logic [REG_W-1:0]  mul_rd_q [MUL_LATENCY];

  logic              haz0, haz1, dep01, drained, state_ok, div_free, dual_en;
  logic              issue0_c, issue1_c;
  logic              mul_push;
  logic [REG_W-1:0]  mul_push_rd;
  logic [NREG-1:0]   sb_set, sb_clr;
  logic              unused_exec;

  // Execute-class flags carry no scheduling constraint of their own
  assign unused_exec = slot0_exec_i ^ slot1_exec_i;

  // Source or destination register still awaiting a long-latency result
  function automatic logic hazard(input logic [NREG-1:0] sb,
                                  input logic [REG_W-1:0] ra,
                                  input logic [REG_W-1:0] rb,
                                  input logic [REG_W-1:0] rd,
                                  input logic rd_v);
    return sb[ra] | sb[rb] | (rd_v & sb[rd]);
  endfunction

  // Issue decision, next FSM state and scoreboard update
  always_comb begin
    state_d     = state_q;
    sb_set      = '0;
    sb_clr      = '0;
    dual_en     = (SUPPORT_DUAL_ISSUE != 0);
    haz0        = hazard(sb_q, slot0_ra_i, slot0_rb_i, slot0_rd_i, slot0_rd_valid_i);
    haz1        = hazard(sb_q, slot1_ra_i, slot1_rb_i, slot1_rd_i, slot1_rd_valid_i);
    drained     = (sb_q == '0) && !div_busy_q;
    state_ok    = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && drained);
    // A completing divide frees the unit for a back-to-back divide
    div_free    = !div_busy_q || wb_div_valid_i;
    dep01       = slot0_rd_valid_i && (slot0_rd_i != '0) &&
                  ((slot1_ra_i == slot0_rd_i) || (slot1_rb_i == slot0_rd_i) ||
                   (slot1_rd_i == slot0_rd_i));

    issue0_c = !rst_i && state_ok && slot0_valid_i && !stall_i && !flush_i && !haz0 &&
               (!slot0_div_i || div_free) && (!slot0_csr_i || drained);
    issue1_c = dual_en && issue0_c && slot1_valid_i &&
               !(slot1_csr_i || slot1_div_i || slot1_mul_i) &&
               !(slot0_lsu_i && slot1_lsu_i) && !(slot0_branch_i && slot1_branch_i) &&
               !slot0_csr_i && !haz1 && !dep01;

    case (state_q)
      ST_RUN: begin
        if (issue0_c && slot0_csr_i)
          state_d = ST_SERIAL;
        else if (slot0_valid_i && slot0_csr_i && !flush_i && !drained)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (issue0_c && slot0_csr_i)
          state_d = ST_SERIAL;
        else if (drained)
          state_d = ST_RUN;
      end
      ST_SERIAL: begin
        if (csr_complete_i)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    mul_push    = issue0_c && slot0_mul_i && slot0_rd_valid_i && (slot0_rd_i != '0);
    mul_push_rd = slot0_rd_i;

    if (wb_load_valid_i)
      sb_clr[wb_load_rd_i] = 1'b1;
    if (wb_div_valid_i && div_busy_q)
      sb_clr[div_rd_q] = 1'b1;
    if (mul_v_q[MUL_LATENCY-1])
      sb_clr[mul_rd_q[MUL_LATENCY-1]] = 1'b1;

    if (issue0_c && slot0_rd_valid_i &&
        ((slot0_lsu_i && slot0_load_i) || slot0_mul_i || slot0_div_i))
      sb_set[slot0_rd_i] = 1'b1;
    if (issue1_c && slot1_rd_valid_i && slot1_lsu_i && slot1_load_i)
      sb_set[slot1_rd_i] = 1'b1;

    // Set wins over a same-cycle clear; x0 is never tracked
    sb_d = ((sb_q & ~sb_clr) | sb_set) & ~NREG'(1);
  end

  // FSM state and scoreboard registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
    end
  end

  // Single divider occupancy and its destination register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_busy_q <= 1'b0;
      div_rd_q   <= '0;
    end else if (issue0_c && slot0_div_i) begin
      div_busy_q <= 1'b1;
      div_rd_q   <= slot0_rd_valid_i ? slot0_rd_i : REG_W'(0);
    end else if (wb_div_valid_i && div_busy_q) begin
      div_busy_q <= 1'b0;
    end
  end

  // Fixed-latency multiply tracker; the tail entry releases its register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
        mul_v_q[i]  <= 1'b0;
        mul_rd_q[i] <= '0;
      end
    end else begin
      mul_v_q[0]  <= mul_push;
      mul_rd_q[0] <= mul_push_rd;
      for (int i = 1; i < int'(MUL_LATENCY); i++) begin
        mul_v_q[i]  <= mul_v_q[i-1];
        mul_rd_q[i] <= mul_rd_q[i-1];
      end
    end
  end

  assign issue0_o     = issue0_c;
  assign issue1_o     = issue1_c;
  assign div_busy_o   = div_busy_q;
  assign serial_o     = (state_q == ST_SERIAL);
  assign scoreboard_o = sb_q;

endmodule

// File: tb/tb_biriscv_issue_sched.sv
// Scoreboard-style bench for biriscv_issue_sched: the driver queues the
// expected per-cycle response, a negedge monitor pops and compares it.
module tb_biriscv_issue_sched;

  typedef struct packed {
    logic       valid, exec, lsu, branch, mul, div, csr, load, rd_valid;
    logic [4:0] rd, ra, rb;
  } slot_t;

  typedef struct {
    string       name;
    logic        i0, i1, busy, serial;
    logic [31:0] sb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  slot_t       s0, s1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        wbl_v = 1'b0, wbd_v = 1'b0, csr_done = 1'b0;
  logic [4:0]  wbl_rd = 5'd0;
  logic        issue0, issue1, div_busy, serial;
  logic [31:0] sb;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  biriscv_issue_sched #(.SUPPORT_DUAL_ISSUE(1), .MUL_LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .slot0_valid_i(s0.valid), .slot0_exec_i(s0.exec), .slot0_lsu_i(s0.lsu),
    .slot0_branch_i(s0.branch), .slot0_mul_i(s0.mul), .slot0_div_i(s0.div),
    .slot0_csr_i(s0.csr), .slot0_load_i(s0.load), .slot0_rd_valid_i(s0.rd_valid),
    .slot0_rd_i(s0.rd), .slot0_ra_i(s0.ra), .slot0_rb_i(s0.rb),
    .slot1_valid_i(s1.valid), .slot1_exec_i(s1.exec), .slot1_lsu_i(s1.lsu),
    .slot1_branch_i(s1.branch), .slot1_mul_i(s1.mul), .slot1_div_i(s1.div),
    .slot1_csr_i(s1.csr), .slot1_load_i(s1.load), .slot1_rd_valid_i(s1.rd_valid),
    .slot1_rd_i(s1.rd), .slot1_ra_i(s1.ra), .slot1_rb_i(s1.rb),
    .stall_i(stall), .flush_i(flush),
    .wb_load_valid_i(wbl_v), .wb_load_rd_i(wbl_rd),
    .wb_div_valid_i(wbd_v), .csr_complete_i(csr_done),
    .issue0_o(issue0), .issue1_o(issue1), .div_busy_o(div_busy),
    .serial_o(serial), .scoreboard_o(sb)
  );

  function automatic slot_t none();
    return '0;
  endfunction
  function automatic slot_t alu(input logic [4:0] rd, ra, rb);
    slot_t s = '0;
    s.valid = 1; s.exec = 1; s.rd_valid = 1; s.rd = rd; s.ra = ra; s.rb = rb;
    return s;
  endfunction
  function automatic slot_t ld(input logic [4:0] rd, ra);
    slot_t s = '0;
    s.valid = 1; s.lsu = 1; s.load = 1; s.rd_valid = 1; s.rd = rd; s.ra = ra;
    return s;
  endfunction
  function automatic slot_t mulop(input logic [4:0] rd, ra, rb);
    slot_t s = alu(rd, ra, rb);
    s.exec = 0; s.mul = 1;
    return s;
  endfunction
  function automatic slot_t divop(input logic [4:0] rd, ra, rb);
    slot_t s = alu(rd, ra, rb);
    s.exec = 0; s.div = 1;
    return s;
  endfunction
  function automatic slot_t csrop(input logic [4:0] rd, ra);
    slot_t s = alu(rd, ra, 5'd0);
    s.exec = 0; s.csr = 1;
    return s;
  endfunction
  function automatic logic [31:0] b(input int n);
    return 32'(1) << n;
  endfunction

  // Queue the response expected during the current cycle, then advance one cycle
  task automatic step(input string name, input logic i0, input logic i1,
                      input logic [31:0] esb, input logic ebusy, input logic eser);
    exp_t e;
    e.name = name; e.i0 = i0; e.i1 = i1; e.sb = esb; e.busy = ebusy; e.serial = eser;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({issue0, issue1, div_busy, serial, sb} !== {e.i0, e.i1, e.busy, e.serial, e.sb}) begin
        n_bad++;
        $display("FAIL %s: got i0=%b i1=%b busy=%b serial=%b sb=%h, want i0=%b i1=%b busy=%b serial=%b sb=%h",
                 e.name, issue0, issue1, div_busy, serial, sb,
                 e.i0, e.i1, e.busy, e.serial, e.sb);
      end
    end
  end

  initial begin
    s0 = none(); s1 = none();
    @(posedge clk); #1;
    step("reset", 0, 0, 0, 0, 0);
    rst = 0;

    // Independent pair dual-issues
    s0 = alu(1, 3, 4); s1 = alu(2, 5, 0);
    step("dual_issue", 1, 1, 0, 0, 0);
    s0 = none(); s1 = none();
    step("dual_sb", 0, 0, 0, 0, 0);

    // Load-use stall until writeback
    s0 = ld(5, 1);
    step("lw_issue", 1, 0, 0, 0, 0);
    s0 = alu(6, 5, 1);
    step("ldu_wait1", 0, 0, b(5), 0, 0);
    step("ldu_wait2", 0, 0, b(5), 0, 0);
    wbl_v = 1; wbl_rd = 5;
    step("ldu_wb", 0, 0, b(5), 0, 0);
    wbl_v = 0;
    step("ldu_go", 1, 0, 0, 0, 0);
    s0 = none();
    step("ldu_sb", 0, 0, 0, 0, 0);

    // Intra-pair RAW blocks slot1 only
    s0 = alu(3, 1, 2); s1 = alu(4, 3, 3);
    step("raw_pair", 1, 0, 0, 0, 0);
    s0 = alu(4, 3, 3); s1 = none();
    step("raw_moved", 1, 0, 0, 0, 0);

    // Two loads cannot pair; first load scoreboards x11
    s0 = ld(11, 1); s1 = ld(12, 2);
    step("lsu_pair", 1, 0, 0, 0, 0);
    s0 = none(); s1 = none();
    wbl_v = 1; wbl_rd = 11;
    step("lsu_sb", 0, 0, b(11), 0, 0);
    wbl_v = 0;
    step("lsu_clr", 0, 0, 0, 0, 0);

    // Stall and flush each block issue
    s0 = alu(1, 2, 3);
    stall = 1;
    step("stall", 0, 0, 0, 0, 0);
    stall = 0; flush = 1;
    step("flush", 0, 0, 0, 0, 0);
    flush = 0; s0 = none();

    // Divider occupancy and back-to-back divide on completion
    s0 = divop(7, 1, 2);
    step("div1", 1, 0, 0, 0, 0);
    s0 = divop(9, 1, 2);
    step("div2_held", 0, 0, b(7), 1, 0);
    step("div2_held2", 0, 0, b(7), 1, 0);
    wbd_v = 1;
    step("div2_go", 1, 0, b(7), 1, 0);
    wbd_v = 0; s0 = none();
    step("div2_busy", 0, 0, b(9), 1, 0);
    wbd_v = 1;
    step("div2_wb", 0, 0, b(9), 1, 0);
    wbd_v = 0;
    step("div_idle", 0, 0, 0, 0, 0);
    wbd_v = 1;
    step("div_stray_wb", 0, 0, 0, 0, 0);
    wbd_v = 0;
    step("div_stray_sb", 0, 0, 0, 0, 0);

    // Multiply holds its register for exactly MUL_LATENCY cycles
    s0 = mulop(8, 1, 2);
    step("mul_issue", 1, 0, 0, 0, 0);
    s0 = none();
    step("mul_sb1", 0, 0, b(8), 0, 0);
    step("mul_sb2", 0, 0, b(8), 0, 0);
    step("mul_done", 0, 0, 0, 0, 0);

    // CSR drains pending load, serialises, then resumes
    s0 = ld(5, 1);
    step("csr_lw", 1, 0, 0, 0, 0);
    s0 = csrop(1, 2);
    step("csr_drain1", 0, 0, b(5), 0, 0);
    step("csr_drain2", 0, 0, b(5), 0, 0);
    wbl_v = 1; wbl_rd = 5;
    step("csr_drain_wb", 0, 0, b(5), 0, 0);
    wbl_v = 0;
    step("csr_issue", 1, 0, 0, 0, 0);
    s0 = alu(10, 1, 2);
    step("serial_hold", 0, 0, 0, 0, 1);
    flush = 1;
    step("serial_flush", 0, 0, 0, 0, 1);
    flush = 0; csr_done = 1;
    step("serial_done", 0, 0, 0, 0, 1);
    csr_done = 0;
    step("serial_exit", 1, 0, 0, 0, 0);

    // Reset in SERIAL clears it
    s0 = csrop(1, 2);
    step("csr2_issue", 1, 0, 0, 0, 0);
    s0 = none();
    step("csr2_serial", 0, 0, 0, 0, 1);
    rst = 1;
    step("rst_in_serial", 0, 0, 0, 0, 1);
    rst = 0;
    step("rst_serial_clr", 0, 0, 0, 0, 0);

    // Reset discards an in-flight multiply and divide
    s0 = mulop(13, 1, 2);
    step("mul_pre_rst", 1, 0, 0, 0, 0);
    s0 = divop(14, 1, 2);
    step("div_pre_rst", 1, 0, b(13), 0, 0);
    s0 = none(); rst = 1;
    step("rst_pending", 0, 0, b(13) | b(14), 1, 0);
    rst = 0; wbd_v = 1;
    step("rst_cleared", 0, 0, 0, 0, 0);
    wbd_v = 0;
    step("rst_stays_clr", 0, 0, 0, 0, 0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/biriscv_issue_sched.md
Name: biriscv_issue_sched

Overview:
- Dual-issue scheduler between the instruction decoders and the execute pipes.
- Each cycle it takes two decoded instruction slots (slot0 older) with unit-class flags and register indices. It decides which slots issue, given register hazards, the single divider and single LSU, and CSR/fence serialisation.
- It owns the register scoreboard for long-latency results (loads, multiplies, divides).

Parameters:
- SUPPORT_DUAL_ISSUE, 1, 0 means slot1 never issues.
- MUL_LATENCY, 2, cycles from mul issue to result bypassable; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slotN_valid_i  in  1  slot N holds an instruction (N=0,1)
- slotN_exec_i / slotN_lsu_i / slotN_branch_i / slotN_mul_i / slotN_div_i / slotN_csr_i  in  1 each  decoder class flags
- slotN_load_i  in  1  LSU op is a load
- slotN_rd_valid_i  in  1  writes rd
- slotN_rd_i / slotN_ra_i / slotN_rb_i  in  5 each  register indices
- stall_i  in  1  execute stage cannot accept
- flush_i  in  1  squash current slots (branch mispredict / exception)
- wb_load_valid_i  in  1  load writeback
- wb_load_rd_i  in  5  load writeback register
- wb_div_valid_i  in  1  divider result
- csr_complete_i  in  1  CSR/fence op retired
- issue0_o  out  1  slot0 issued this cycle
- issue1_o  out  1  slot1 issued this cycle
- div_busy_o  out  1  divider occupied
- serial_o  out  1  in SERIAL state
- scoreboard_o  out  32  pending-write mask, bit 0 always 0

Behaviour:
- Reset:
  - Scoreboard = 0, div_busy_o = 0, mul pipe empty, state = RUN.
  - issue0_o = issue1_o = 0, serial_o = 0.
- issue outputs are combinational. Scoreboard, div, mul-pipe and FSM state update on clk_i.
- Hazard(slot) is true if any applies (x0 never hazards):
  - ra/rb in scoreboard;
  - rd_valid and rd in scoreboard (WAW).
- FSM states:
  - RUN: normal issue.
  - DRAIN: slot0 is csr but scoreboard != 0 or div busy. No issue. Go to RUN-issue once drained.
  - SERIAL: csr issued. No issue until csr_complete_i, then RUN next cycle.
- issue0 requires all of:
  - state RUN (or DRAIN with drain condition met);
  - slot0_valid, !stall_i, !flush_i, !hazard(slot0);
  - !(slot0_div && div_busy);
  - if csr: scoreboard == 0 and !div_busy.
- csr issue → SERIAL next cycle. CSR with sb nonzero → DRAIN.
- issue1 requires all of:
  - SUPPORT_DUAL_ISSUE and issue0;
  - slot1_valid;
  - slot1 not csr/div/mul;
  - not both slots lsu; not both slots branch;
  - slot0 not csr;
  - !hazard(slot1);
  - slot0_rd_valid && slot0_rd != 0 → slot1 ra, rb, rd ≠ slot0_rd.
- Scoreboard set on issue of load (slotN_load_i), div, or mul with rd_valid and rd != 0.
- Scoreboard clear:
  - wb_load_valid_i clears wb_load_rd_i.
  - wb_div_valid_i clears the latched div rd.
  - A mul entry clears automatically when it leaves the MUL_LATENCY-deep shift pipe of {valid, rd}.
- Same-cycle set and clear of one register: set wins.
- Divider: div_busy set on div issue, latched div rd stored; cleared on wb_div_valid_i. A div issue in the same cycle as a div completion is allowed (busy stays 1, new rd latched).
- flush_i:
  - Blocks issue that cycle only.
  - Outstanding load/div/mul entries are kept and clear normally.
  - Does not exit SERIAL.
- Mid-operation reset discards all state, including pending writebacks. Writebacks arriving afterward must not set bits.
- wb_* for a register whose bit is already clear is ignored.

Test Plan:
1. Reset, then slot0 add x1 / slot1 addi x2 both valid, no hazards → issue0_o = issue1_o = 1 the same cycle; scoreboard stays 0.
2. slot0 lw x5 issues; next cycle slot0 add x6,x5,x1 → issue0_o = 0 until wb_load_valid_i with rd = 5. Issues the cycle after the clear; scoreboard bit 5 toggles 1→0.
3. slot0 addi x3, slot1 add x4,x3,x3 → issue0_o = 1, issue1_o = 0 (intra-pair RAW). The next cycle slot1 content moved to slot0 issues.
4. div x7 issues, then a second div → held while div_busy_o = 1. wb_div_valid_i → the second div issues the same cycle the first completes (busy stays 1).
5. mul x8 with MUL_LATENCY = 2 → scoreboard bit 8 = 1 for exactly 2 cycles, then clears with no writeback input.
6. csrrw with scoreboard bit 5 pending → DRAIN, no issue. Load writeback → csr issues, serial_o = 1, no issue until csr_complete_i, then RUN. Assert rst_i mid-SERIAL → serial_o = 0 next cycle.
